// File: rtl/keypad_scan.sv
// Row-scanning reader for a 4x4 active-low matrix keypad: rotates the row select,
// samples synchronized columns, debounces whole scans and reports accepted keys.
module keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [CNT_W:0]   DB_TARGET = (CNT_W + 1)'(DEBOUNCE_SCANS);
    localparam logic [CNT_W:0]   CNT_INC   = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_t;

    // Number of low columns, saturated at 2 ("two or more").
    function automatic logic [1:0] low_count_sat(input logic [3:0] low);
        logic [2:0] n;
        n = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        return (n > 3'd1) ? 2'd2 : n[1:0];
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] low);
        if (low[0]) return 2'd0;
        else if (low[1]) return 2'd1;
        else if (low[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Hit counter saturating at 2; anything past one hit is already MULTI.
    function automatic logic [1:0] hits_sat_add(input logic [1:0] a, input logic b);
        if (a == 2'd2) return 2'd2;
        return a + {1'b0, b};
    endfunction

    function automatic logic [3:0] row_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    logic [3:0]       col_p0, col_p1;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       r;

    logic [1:0]       hit_cnt;
    logic             acc_multi;
    logic [3:0]       acc_code;

    logic [3:0]       col_low;
    logic [1:0]       row_lows;
    logic             row_hit, row_multi;
    logic [3:0]       row_code;
    logic [1:0]       scan_hits;
    logic             scan_multi;
    logic [3:0]       scan_code;
    scan_t            scan_res;
    logic             scan_end;

    state_t           state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_nxt;
    logic             cnt_done;
    logic             same_key;

    // Stage p0/p1: two-flop column synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0 <= 4'b1111;
            col_p1 <= 4'b1111;
        end else begin
            col_p0 <= col_in;
            col_p1 <= col_p0;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            r       <= 2'd0;
            row_out <= 4'b1110;
        end else if (tick) begin
            div_cnt <= '0;
            r       <= r + 2'd1;
            row_out <= row_sel(r + 2'd1);
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Row sample and whole-scan classification, valid at tick
    always_comb begin
        col_low    = ~col_p1;
        row_lows   = low_count_sat(col_low);
        row_hit    = (row_lows == 2'd1);
        row_multi  = (row_lows == 2'd2);
        row_code   = {r, low_index(col_low)};
        scan_hits  = hits_sat_add(hit_cnt, row_hit);
        scan_multi = acc_multi | row_multi;
        scan_code  = row_hit ? row_code : acc_code;
        scan_end   = tick && (r == 2'd3);
        scan_res   = SCAN_MULTI;
        if (scan_hits == 2'd0 && !scan_multi)
            scan_res = SCAN_NONE;
        else if (scan_hits == 2'd1 && !scan_multi)
            scan_res = SCAN_SINGLE;
        same_key   = (scan_code == cand);
        cnt_nxt    = {1'b0, cnt} + CNT_INC;
        cnt_done   = (cnt_nxt >= DB_TARGET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= 2'd0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (tick) begin
            if (r == 2'd3) begin
                hit_cnt   <= 2'd0;
                acc_multi <= 1'b0;
                acc_code  <= 4'd0;
            end else begin
                hit_cnt   <= scan_hits;
                acc_multi <= scan_multi;
                if (row_hit)
                    acc_code <= row_code;
            end
        end
    end

    // Debounce FSM, stepped once per completed scan; key_valid is a one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (scan_res == SCAN_SINGLE) begin
                            cand <= scan_code;
                            cnt  <= CNT_ONE;
                            if (DB_TARGET == CNT_INC) begin
                                state     <= PRESSED;
                                key_code  <= scan_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (scan_res == SCAN_SINGLE && same_key) begin
                            if (cnt_done) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt_nxt[CNT_W-1:0];
                            end
                        end else if (scan_res == SCAN_SINGLE) begin
                            cand <= scan_code;
                            cnt  <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (!(scan_res == SCAN_SINGLE && same_key)) begin
                            if (scan_res == SCAN_NONE && DB_TARGET == CNT_INC) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= (scan_res == SCAN_NONE) ? CNT_ONE : '0;
                            end
                        end
                    end
                    RELEASE: begin
                        if (scan_res == SCAN_NONE) begin
                            if (cnt_done) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                cnt <= cnt_nxt[CNT_W-1:0];
                            end
                        end else if (scan_res == SCAN_SINGLE && same_key) begin
                            state <= PRESSED;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Row-scanning reader for a 4x4 matrix keypad. It is the input-side counterpart of the LED-matrix row-scan drivers. It drives one active-low row at a time and samples the active-low column lines. Each key is debounced over whole scans and reported as a one-cycle key_valid strobe with a 4-bit code, which the game controller uses for code entry.

Parameters:
SCAN_DIV, 1000, clk cycles per row slot; must be >= 4
DEBOUNCE_SCANS, 4, consecutive full scans with a stable result needed to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
col_in  input  4  keypad columns, active-low (pulled up externally)
row_out  output  4  row select, active-low one-hot
key_code  output  4  last accepted key, {row[1:0], col[1:0]}
key_valid  output  1  one-cycle strobe when a press is accepted
key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset (async, rst_n=0):
  - row_out=4'b1110; row index r=0; div_cnt=0.
  - state=IDLE; key_code=0; key_valid=0; key_held=0.
  - Synchronizer flops=4'b1111; scan accumulators cleared.
  - Leaving reset starts a fresh scan at row 0; no history survives reset.
- Synchronizer: col_in passes through a 2-flop synchronizer, reset to 4'b1111. Only the synchronized value is used.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick=1 when div_cnt==SCAN_DIV-1.
- Row scan:
  - r advances on tick and wraps 3->0.
  - row_out=~(1<<r), registered.
  - Rows rotate continuously in every FSM state.
- Row sample, at tick, before r advances:
  - Exactly one synchronized column low -> row hit, code={r,c}.
  - No columns low -> no hit.
  - Two or more columns low -> multi.
- Scan result, evaluated at the tick that ends the r=3 slot:
  - NONE: no hit in any row.
  - SINGLE(code): exactly one hit total and no multi.
  - MULTI: anything else. This covers ghosting and multi-key chords.
  - Accumulators clear for the next scan.
- FSM, advanced only at scan-end ticks:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to DEBOUNCE; if DEBOUNCE_SCANS==1, go straight to PRESSED.
    - Else stay.
  - DEBOUNCE:
    - SINGLE(cand): cnt+1; when cnt reaches DEBOUNCE_SCANS, go to PRESSED.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
  - On entry to PRESSED: key_code<=cand, key_valid=1 for exactly one clk (the cycle after the scan-end tick), key_held<=1.
  - PRESSED:
    - SINGLE(cand): stay.
    - Anything else: go to RELEASE, with cnt=1 if NONE, else cnt=0.
  - RELEASE:
    - NONE: cnt+1; at DEBOUNCE_SCANS, go to IDLE and key_held<=0.
    - SINGLE(cand): return to PRESSED with no new key_valid.
    - SINGLE(other) or MULTI: cnt=0 and stay. A new key needs a full release first; no rollover.
- key_code holds its value until the next accepted press. It is not cleared on release.
- Press latency: key_valid rises 1 clk after the scan-end tick of the DEBOUNCE_SCANS-th consecutive matching scan.
- Release latency: key_held falls 1 clk after the scan-end tick of the DEBOUNCE_SCANS-th consecutive NONE scan.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, full scan = 16 clk; keypad model pulls col c low while row_out[r]=0 for each pressed key (r,c)):
1. Reset, then run with no keys:
   - row_out sequence 1110,1101,1011,0111, changing every 4 clk and repeating every 16.
   - key_valid, key_held and key_code stay 0.
2. Press (2,1) for 5 scans, then release:
   - Exactly one key_valid pulse, at the end of the 2nd full scan containing the press.
   - key_code=4'h9; key_held=1 until 2 empty scans complete, then 0.
   - key_code stays 4'h9.
3. Bounce: press (1,3) for one full scan only, then release -> no key_valid; key_held=0; state back to IDLE.
4. Ghost/chord:
   - Press (0,0)+(3,3) together for 4 scans -> MULTI every scan, no key_valid.
   - Press (1,0)+(1,2) in the same row -> same result.
5. Slide: hold (0,2) until accepted (key_code=4'h2), then switch to (3,0) without a gap:
   - No key_valid while (3,0) is held; key_held stays 1.
   - Release all -> key_held falls after 2 empty scans.
   - Press (3,0) again -> key_valid with key_code=4'hC.
6. Reset mid-press:
   - Drop rst_n for 3 clk during PRESSED, not aligned to clk -> outputs go to reset values immediately.
   - Key still held after reset -> fresh debounce, and a new key_valid with the same code after 2 scans.
